regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Integer register file for the RV32 core. It is the receiving end of the write-back interface: it consumes wr_enable, wr_address and wrdata from the write-back stage.
- Provides two combinational read ports to decode/issue.
- Keeps a per-register pending-write counter, which gives decode a RAW/WAW stall.
- Sits between the decode/issue stage and the write-back stage.

Parameters:
- XLEN, 32, data width of each register.
- NUM_REGS, 32, number of architectural registers; x0 included.
- PEND_W, 2, width of each pending-write counter; max in-flight writes per register = 2**PEND_W-1.

Ports:
- i_clk  input  1  clock; all state updates on posedge.
- i_rstn  input  1  reset, asynchronous, active-low.
- wr_enable  input  1  write strobe from write-back.
- wr_address  input  5  write destination register.
- wrdata  input  XLEN  write data.
- i_issue_valid  input  1  decode presents an instruction this cycle.
- i_issue_rd  input  5  destination of the issuing instruction; 0 means no destination.
- i_rs1_addr  input  5  read port 1 address.
- i_rs2_addr  input  5  read port 2 address.
- o_rs1_data  output  XLEN  read port 1 data (combinational).
- o_rs2_data  output  XLEN  read port 2 data (combinational).
- o_stall  output  1  issue must not proceed this cycle (combinational).
- o_busy_vec  output  NUM_REGS  bit n = counter[n]!=0 (registered state).
- o_underflow  output  1  sticky error flag.

Behaviour:
- Reset (async, i_rstn=0):
  - all registers = 0, all counters = 0, o_underflow = 0.
  - o_busy_vec = 0; o_stall = 0 (no pending counters).
  - Reset mid-operation discards all in-flight pending state.
- Register write:
  - on posedge, if wr_enable && wr_address!=0, then regs[wr_address] <= wrdata.
  - Writes to x0 are ignored; x0 always reads 0.
- Reads:
  - o_rsN_data = regs[i_rsN_addr]; address 0 returns 0.
  - Same-cycle write bypass is governed by REGFILE_BYPASS_EN.
- Stall rule (combinational), o_stall = i_issue_valid && (any of):
  - rs1 hazard: i_rs1_addr!=0 && counter[rs1]!=0 && !retire_hit(rs1).
  - rs2 hazard: same rule on i_rs2_addr.
  - WAW full: i_issue_rd!=0 && counter[rd]==2**PEND_W-1.
- retire_hit(r) is defined only with REGFILE_BYPASS_EN: wr_enable && wr_address==r && counter[r]==1. Without the macro it is always 0.
- Counters, on posedge:
  - inc = i_issue_valid && !o_stall && i_issue_rd!=0, applied to counter[i_issue_rd].
  - dec = wr_enable && wr_address!=0, applied to counter[wr_address].
  - inc and dec on the same register in the same cycle: counter unchanged.
  - dec on a counter already at 0: counter holds 0 and o_underflow <= 1 (sticky until reset).
  - Saturation is prevented by the WAW-full stall; a counter never wraps.
- Latency:
  - A write is visible on the read ports at 0 cycles with bypass, or 1 cycle without.
  - Counter and busy updates are visible the cycle after the event.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined:
  - if wr_enable && wr_address==i_rsN_addr && i_rsN_addr!=0, then o_rsN_data = wrdata (write-first).
  - retire_hit is active, so the final pending write to a register does not stall a same-cycle reader.
- Undefined:
  - reads return array contents only, so a same-cycle write is seen next cycle.
  - retire_hit is 0, so the reader stalls one extra cycle.

Decomposition:
- Shared package riscv_pkg:
  - XLEN, REG_ADDR_W=5, NUM_REGS.
  - typedef reg_addr_t (logic [4:0]) and xlen_t (logic [XLEN-1:0]).
- Sub-module pend_counter: one PEND_W-bit up/down counter with saturation-hold and underflow output, generate-instantiated for registers 1..NUM_REGS-1.

Test Plan:
- Reset release: read all 32 addresses -> all 0; o_stall=0, o_busy_vec=0, o_underflow=0.
- wr_enable=1, wr_address=5, wrdata=0xDEADBEEF, rs1=5:
  - bypass build -> o_rs1_data=0xDEADBEEF same cycle.
  - no-bypass build -> 0 that cycle, 0xDEADBEEF next cycle.
- Write 0x1234 to x0 -> reading x0 gives 0; counter[0] untouched; o_underflow stays 0.
- Issue rd=7, then next cycle issue rs1=7 -> o_stall=1, o_busy_vec[7]=1; write-back to 7 -> bypass build releases stall the same cycle, no-bypass build the next cycle.
- Issue rd=3 three times with no write-back (PEND_W=2) -> counter=3; 4th issue rd=3 -> o_stall=1, counter stays 3.
- Same cycle issue rd=9 and write-back wr_address=9 with counter[9]=1 -> counter stays 1.
- Write-back to 10 with counter[10]=0 -> o_underflow=1 and stays 1.
- Assert i_rstn=0 mid-sequence -> counters, registers and flags cleared immediately.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 integer-datapath types: register address and data widths.
package riscv_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;
endpackage

// File: rtl/pend_counter.sv
// One per-register pending-write counter: up on issue, down on write-back,
// holds at both ends and flags a decrement that has nothing to retire.
module pend_counter #(
  parameter int PEND_W = 2
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] cnt,
  output logic              underflow
);
  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic up, dn;

  // Simultaneous inc/dec cancel, so neither moves the count nor flags underflow.
  assign up        = inc && !dec && (cnt != CNT_MAX);
  assign dn        = dec && !inc && (cnt != '0);
  assign underflow = dec && !inc && (cnt == '0);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)  cnt <= '0;
    else if (up)  cnt <= cnt + 1'b1;
    else if (dn)  cnt <= cnt - 1'b1;
  end
endmodule

// File: rtl/regfile_scoreboard.sv
// RV32 integer register file with per-register pending-write scoreboard.
// Optional macro REGFILE_BYPASS_EN: write-first read bypass plus retire-hit stall release.
module regfile_scoreboard #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int PEND_W   = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  wr_enable,
  input  riscv_pkg::reg_addr_t  wr_address,
  input  logic [XLEN-1:0]       wrdata,
  input  logic                  i_issue_valid,
  input  riscv_pkg::reg_addr_t  i_issue_rd,
  input  riscv_pkg::reg_addr_t  i_rs1_addr,
  input  riscv_pkg::reg_addr_t  i_rs2_addr,
  output logic [XLEN-1:0]       o_rs1_data,
  output logic [XLEN-1:0]       o_rs2_data,
  output logic                  o_stall,
  output logic [NUM_REGS-1:0]   o_busy_vec,
  output logic                  o_underflow
);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [NUM_REGS-1:0][XLEN-1:0]   regs;
  logic [NUM_REGS-1:0][PEND_W-1:0] cnt;
  logic [NUM_REGS-1:0]             uf_vec;
  logic wr_nz, issue_inc;
  logic rs1_retire, rs2_retire, rs1_haz, rs2_haz, waw_full;

  assign wr_nz = wr_enable && (wr_address != '0);

  // x0 is never written, so its entry stays at its reset value of 0.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)    regs <= '0;
    else if (wr_nz) regs[wr_address] <= wrdata;
  end

  always_comb begin
    o_rs1_data = regs[i_rs1_addr];
    o_rs2_data = regs[i_rs2_addr];
`ifdef REGFILE_BYPASS_EN
    if (wr_nz && (wr_address == i_rs1_addr)) o_rs1_data = wrdata;
    if (wr_nz && (wr_address == i_rs2_addr)) o_rs2_data = wrdata;
`endif
  end

`ifdef REGFILE_BYPASS_EN
  // Last outstanding write landing this cycle is forwarded, so it need not stall.
  assign rs1_retire = wr_enable && (wr_address == i_rs1_addr) && (cnt[i_rs1_addr] == PEND_ONE);
  assign rs2_retire = wr_enable && (wr_address == i_rs2_addr) && (cnt[i_rs2_addr] == PEND_ONE);
`else
  assign rs1_retire = 1'b0;
  assign rs2_retire = 1'b0;
`endif

  assign rs1_haz   = (i_rs1_addr != '0) && (cnt[i_rs1_addr] != '0) && !rs1_retire;
  assign rs2_haz   = (i_rs2_addr != '0) && (cnt[i_rs2_addr] != '0) && !rs2_retire;
  assign waw_full  = (i_issue_rd != '0) && (cnt[i_issue_rd] == PEND_MAX);
  assign o_stall   = i_issue_valid && (rs1_haz || rs2_haz || waw_full);
  assign issue_inc = i_issue_valid && !o_stall && (i_issue_rd != '0);

  assign cnt[0]        = '0;
  assign uf_vec[0]     = 1'b0;
  assign o_busy_vec[0] = 1'b0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_pend
    pend_counter #(.PEND_W(PEND_W)) u_pend (
      .i_clk     (i_clk),
      .i_rstn    (i_rstn),
      .inc       (issue_inc && (i_issue_rd == riscv_pkg::reg_addr_t'(g))),
      .dec       (wr_nz && (wr_address == riscv_pkg::reg_addr_t'(g))),
      .cnt       (cnt[g]),
      .underflow (uf_vec[g])
    );
    assign o_busy_vec[g] = |cnt[g];
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)      o_underflow <= 1'b0;
    else if (|uf_vec) o_underflow <= 1'b1;
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard with an array/counter reference model
// checked every cycle, plus hand-computed literal checks.
module tb_regfile_scoreboard;
  logic        i_clk = 1'b0, i_rstn = 1'b0;
  logic        wr_enable = 1'b0, i_issue_valid = 1'b0;
  logic [4:0]  wr_address = '0, i_issue_rd = '0, i_rs1_addr = '0, i_rs2_addr = '0;
  logic [31:0] wrdata = '0;
  logic [31:0] o_rs1_data, o_rs2_data, o_busy_vec;
  logic        o_stall, o_underflow;

  int n_cmp = 0, n_bad = 0;
  bit chk_en = 1'b0;

  bit [31:0] m_reg [32];
  int        m_cnt [32];
  bit        m_uf;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_scoreboard dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .wr_enable(wr_enable), .wr_address(wr_address),
    .wrdata(wrdata), .i_issue_valid(i_issue_valid), .i_issue_rd(i_issue_rd),
    .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr), .o_rs1_data(o_rs1_data),
    .o_rs2_data(o_rs2_data), .o_stall(o_stall), .o_busy_vec(o_busy_vec),
    .o_underflow(o_underflow)
  );

  always #5 i_clk = ~i_clk;

  function automatic bit m_hit(input logic [4:0] r);
    return BYP && wr_enable && (wr_address == r) && (m_cnt[r] == 1);
  endfunction

  function automatic bit m_stall();
    bit h1, h2, full;
    h1   = (i_rs1_addr != 0) && (m_cnt[i_rs1_addr] > 0) && !m_hit(i_rs1_addr);
    h2   = (i_rs2_addr != 0) && (m_cnt[i_rs2_addr] > 0) && !m_hit(i_rs2_addr);
    full = (i_issue_rd != 0) && (m_cnt[i_issue_rd] == 3);
    return i_issue_valid && (h1 || h2 || full);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (BYP && wr_enable && wr_address == a) return wrdata;
    return m_reg[a];
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] v = '0;
    for (int i = 1; i < 32; i++) v[i] = (m_cnt[i] != 0);
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin m_reg[i] = '0; m_cnt[i] = 0; end
    m_uf = 1'b0;
  endtask

  // Advance the model by one clock using the inputs held across that edge.
  task automatic m_step();
    bit inc, dec;
    inc = i_issue_valid && !m_stall() && (i_issue_rd != 0);
    dec = wr_enable && (wr_address != 0);
    if (dec) m_reg[wr_address] = wrdata;
    if (!(inc && dec && i_issue_rd == wr_address)) begin
      if (inc) m_cnt[i_issue_rd]++;
      if (dec) begin
        if (m_cnt[wr_address] == 0) m_uf = 1'b1;
        else m_cnt[wr_address]--;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit iv, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input bit we, input logic [4:0] wa,
                       input logic [31:0] wd);
    @(posedge i_clk);
    if (i_rstn) m_step();
    #1;
    i_issue_valid = iv; i_issue_rd = rd; i_rs1_addr = rs1; i_rs2_addr = rs2;
    wr_enable = we; wr_address = wa; wrdata = wd;
  endtask

  task automatic idle(); drive(0, 0, 0, 0, 0, 0, 0); endtask

  always @(negedge i_clk) begin
    if (chk_en && i_rstn) begin
      chk("m_rs1", o_rs1_data, m_read(i_rs1_addr));
      chk("m_rs2", o_rs2_data, m_read(i_rs2_addr));
      chk("m_stall", {31'b0, o_stall}, {31'b0, m_stall()});
      chk("m_busy", o_busy_vec, m_busy());
      chk("m_uf", {31'b0, o_underflow}, {31'b0, m_uf});
    end
  end

  initial begin
    m_reset();
    repeat (2) @(posedge i_clk);
    #1 i_issue_valid = 1'b1; i_issue_rd = 5'd3; i_rs1_addr = 5'd7;
    #1;
    chk("rst_stall", {31'b0, o_stall}, 32'h0);
    chk("rst_busy", o_busy_vec, 32'h0);
    chk("rst_uf", {31'b0, o_underflow}, 32'h0);
    chk("rst_rd", o_rs1_data, 32'h0);
    i_issue_valid = 1'b0; i_issue_rd = '0; i_rs1_addr = '0;
    #1 i_rstn = 1'b1;
    chk_en = 1'b1;

    for (int k = 0; k < 16; k++) begin
      drive(0, 0, 5'(2*k), 5'(2*k+1), 0, 0, 0);
      #1 chk("rel_rd", o_rs1_data | o_rs2_data, 32'h0);
    end

    // Write/read latency on x5 (a pending issue first so the write-back is legal)
    drive(1, 5, 0, 0, 0, 0, 0);
    drive(0, 0, 5, 0, 1, 5, 32'hDEADBEEF);
    #1 chk("byp_rd", o_rs1_data, BYP ? 32'hDEADBEEF : 32'h0);
    drive(0, 0, 5, 0, 0, 0, 0);
    #1 chk("next_rd", o_rs1_data, 32'hDEADBEEF);

    // x0 write ignored
    drive(0, 0, 0, 0, 1, 0, 32'h1234);
    #1 chk("x0_rd", o_rs1_data, 32'h0);
    idle();
    #1 chk("x0_uf", {31'b0, o_underflow}, 32'h0);
    chk("x0_busy", o_busy_vec, 32'h0);

    // RAW on x7 released by its write-back
    drive(1, 7, 0, 0, 0, 0, 0);
    drive(1, 0, 7, 0, 0, 0, 0);
    #1 chk("raw_stall", {31'b0, o_stall}, 32'h1);
    chk("raw_busy7", {31'b0, o_busy_vec[7]}, 32'h1);
    drive(1, 0, 7, 0, 1, 7, 32'h77);
    #1 chk("raw_wb_stall", {31'b0, o_stall}, BYP ? 32'h0 : 32'h1);
    drive(1, 0, 7, 0, 0, 0, 0);
    #1 chk("raw_after", {31'b0, o_stall}, 32'h0);
    chk("raw_data", o_rs1_data, 32'h77);

    // WAW full on x3
    repeat (3) drive(1, 3, 0, 0, 0, 0, 0);
    drive(1, 3, 0, 0, 0, 0, 0);
    #1 chk("waw_full", {31'b0, o_stall}, 32'h1);
    chk("waw_busy3", {31'b0, o_busy_vec[3]}, 32'h1);
    drive(1, 3, 0, 0, 0, 0, 0);
    #1 chk("waw_hold", {31'b0, o_stall}, 32'h1);
    for (int k = 0; k < 3; k++) drive(0, 0, 0, 0, 1, 3, 32'h33 + k);
    idle();
    #1 chk("waw_drain", {31'b0, o_busy_vec[3]}, 32'h0);
    chk("waw_uf", {31'b0, o_underflow}, 32'h0);

    // Same-cycle inc/dec on x9
    drive(1, 9, 0, 0, 0, 0, 0);
    drive(1, 9, 0, 0, 1, 9, 32'h99);
    idle();
    #1 chk("incdec_busy9", {31'b0, o_busy_vec[9]}, 32'h1);
    drive(0, 0, 0, 0, 1, 9, 32'h98);
    idle();
    #1 chk("incdec_clr9", {31'b0, o_busy_vec[9]}, 32'h0);
    chk("incdec_uf", {31'b0, o_underflow}, 32'h0);

    // Underflow on x10, sticky
    drive(0, 0, 10, 0, 1, 10, 32'hAA);
    idle();
    #1 chk("uf_set", {31'b0, o_underflow}, 32'h1);
    chk("uf_busy10", {31'b0, o_busy_vec[10]}, 32'h0);
    repeat (3) idle();
    #1 chk("uf_sticky", {31'b0, o_underflow}, 32'h1);

    // Mid-operation reset
    drive(1, 12, 0, 0, 0, 0, 0);
    drive(1, 13, 0, 0, 0, 0, 0);
    drive(0, 0, 5, 7, 0, 0, 0);
    #1 chk("pre_rst_busy", o_busy_vec, 32'h0000_3000);
    #1 i_rstn = 1'b0;
    m_reset();
    #1 chk("mid_rst_busy", o_busy_vec, 32'h0);
    chk("mid_rst_uf", {31'b0, o_underflow}, 32'h0);
    chk("mid_rst_rs1", o_rs1_data, 32'h0);
    chk("mid_rst_rs2", o_rs2_data, 32'h0);
    @(posedge i_clk);
    #2 i_rstn = 1'b1;
    drive(1, 12, 0, 0, 0, 0, 0);
    drive(1, 0, 12, 0, 0, 0, 0);
    #1 chk("post_rst_stall", {31'b0, o_stall}, 32'h1);
    drive(0, 0, 12, 0, 1, 12, 32'h5);
    idle();
    #1 chk("post_rst_busy", o_busy_vec, 32'h0);
    chk("post_rst_uf", {31'b0, o_underflow}, 32'h0);
    repeat (2) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
